// File: rtl/lsu_pkg.sv
// Shared constants for the load/store stage: ls_info bit indices, FSM states and size masks.
// Helper functions decode the access size and detect misaligned offsets.
package lsu_pkg;

  localparam int unsigned LsInfoW = 11;

  localparam int unsigned LsLb  = 10;
  localparam int unsigned LsLh  = 9;
  localparam int unsigned LsLw  = 8;
  localparam int unsigned LsLd  = 7;
  localparam int unsigned LsLbu = 6;
  localparam int unsigned LsLhu = 5;
  localparam int unsigned LsLwu = 4;
  localparam int unsigned LsSb  = 3;
  localparam int unsigned LsSh  = 2;
  localparam int unsigned LsSw  = 1;
  localparam int unsigned LsSd  = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SzByte   = 2'd0,
    SzHalf   = 2'd1,
    SzWord   = 2'd2,
    SzDouble = 2'd3
  } lsu_size_e;

  // Offset bits that must be zero for a naturally aligned access.
  localparam logic [2:0] AlignByte   = 3'b000;
  localparam logic [2:0] AlignHalf   = 3'b001;
  localparam logic [2:0] AlignWord   = 3'b011;
  localparam logic [2:0] AlignDouble = 3'b111;

  function automatic lsu_size_e ls_size(input logic [LsInfoW-1:0] info);
    lsu_size_e sz;
    sz = SzByte;
    if (info[LsLh] || info[LsLhu] || info[LsSh]) sz = SzHalf;
    if (info[LsLw] || info[LsLwu] || info[LsSw]) sz = SzWord;
    if (info[LsLd] || info[LsSd]) sz = SzDouble;
    return sz;
  endfunction

  function automatic logic [2:0] ls_align_mask(input lsu_size_e sz);
    logic [2:0] m;
    case (sz)
      SzHalf:   m = AlignHalf;
      SzWord:   m = AlignWord;
      SzDouble: m = AlignDouble;
      default:  m = AlignByte;
    endcase
    return m;
  endfunction

  function automatic logic ls_misaligned(input logic [LsInfoW-1:0] info, input logic [2:0] off);
    return |(off & ls_align_mask(ls_size(info)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and store replicate/byte-mask generation.
// The offset is truncated to the natural alignment of the access size.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [LsInfoW-1:0] ls_info,
  input  logic [2:0]         offset,
  input  logic [63:0]        wdata,
  input  logic [63:0]        rdata,
  output logic [63:0]        store_data,
  output logic [7:0]         store_mask,
  output logic [63:0]        load_data
);

  lsu_size_e   size;
  logic [2:0]  off;
  logic [63:0] shifted;
  logic        is_store;

  assign size     = ls_size(ls_info);
  assign off      = offset & ~ls_align_mask(size);
  assign shifted  = rdata >> {off, 3'b000};
  assign is_store = |ls_info[LsSb:LsSd];

  always_comb begin
    store_data = wdata;
    store_mask = 8'h00;
    case (size)
      SzByte: begin
        store_data = {8{wdata[7:0]}};
        store_mask = 8'h01 << off;
      end
      SzHalf: begin
        store_data = {4{wdata[15:0]}};
        store_mask = 8'h03 << off;
      end
      SzWord: begin
        store_data = {2{wdata[31:0]}};
        store_mask = 8'h0F << off;
      end
      default: store_mask = 8'hFF;
    endcase
    // Non-store entries (including the reset state) must not present byte enables.
    if (!is_store) store_mask = 8'h00;
  end

  always_comb begin
    load_data = shifted;
    if (ls_info[LsLb])       load_data = {{56{shifted[7]}}, shifted[7:0]};
    else if (ls_info[LsLh])  load_data = {{48{shifted[15]}}, shifted[15:0]};
    else if (ls_info[LsLw])  load_data = {{32{shifted[31]}}, shifted[31:0]};
    else if (ls_info[LsLbu]) load_data = {56'd0, shifted[7:0]};
    else if (ls_info[LsLhu]) load_data = {48'd0, shifted[15:0]};
    else if (ls_info[LsLwu]) load_data = {32'd0, shifted[31:0]};
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: EX/LS pipeline register, data-memory handshake FSM and write-back.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of truncating the offset.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_valid,
  input  logic               i_rd_wen,
  input  logic [4:0]         i_rd_addr,
  input  logic [DATA_W-1:0]  i_rd_data,
  input  logic [ADDR_W-1:0]  i_mem_addr,
  input  logic [DATA_W-1:0]  i_mem_wdata,
  input  logic [LsInfoW-1:0] i_ls_info,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  output logic               o_stall,
  output logic [DATA_W-1:0]  o_fwd_rd_data,
  output logic               o_dmem_valid,
  input  logic               i_dmem_ready,
  output logic [ADDR_W-1:0]  o_dmem_addr,
  output logic               o_dmem_wen,
  output logic [DATA_W-1:0]  o_dmem_wdata,
  output logic [7:0]         o_dmem_wmask,
  input  logic               i_dmem_rvalid,
  input  logic [DATA_W-1:0]  i_dmem_rdata,
  output logic               o_wb_valid,
  output logic               o_rd_wen,
  output logic [4:0]         o_rd_addr,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic               o_misalign
);

  lsu_state_e         state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [LsInfoW-1:0] ls_info_q;
  logic               is_load_q;
  logic               is_store_q;
  logic               rd_wen_q;
  logic [4:0]         rd_addr_q;
  logic               misalign_q;
  logic [DATA_W-1:0]  load_data;
  logic               is_mem;
  logic               acc_misalign;

  assign is_mem = i_mem_read | i_mem_write;

`ifdef LSU_MISALIGN_CHECK_EN
  assign acc_misalign = ls_misaligned(i_ls_info, i_mem_addr[2:0]);
`else
  assign acc_misalign = 1'b0;
`endif

  assign o_stall     = (state_q != StIdle);
  assign o_misalign  = misalign_q;
  assign o_dmem_addr = {addr_q[ADDR_W-1:3], 3'b000};
  assign o_dmem_wen  = is_store_q;

  lsu_align u_align (
    .ls_info    (ls_info_q),
    .offset     (addr_q[2:0]),
    .wdata      (wdata_q),
    .rdata      (i_dmem_rdata),
    .store_data (o_dmem_wdata),
    .store_mask (o_dmem_wmask),
    .load_data  (load_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      ls_info_q     <= '0;
      is_load_q     <= 1'b0;
      is_store_q    <= 1'b0;
      rd_wen_q      <= 1'b0;
      rd_addr_q     <= '0;
      misalign_q    <= 1'b0;
      o_fwd_rd_data <= '0;
      o_dmem_valid  <= 1'b0;
      o_wb_valid    <= 1'b0;
      o_rd_wen      <= 1'b0;
      o_rd_addr     <= '0;
      o_rd_data     <= '0;
    end else begin
      o_wb_valid <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            addr_q        <= i_mem_addr;
            wdata_q       <= i_mem_wdata;
            ls_info_q     <= i_ls_info;
            is_load_q     <= i_mem_read;
            is_store_q    <= i_mem_write & ~i_mem_read;
            rd_wen_q      <= i_rd_wen;
            rd_addr_q     <= i_rd_addr;
            o_fwd_rd_data <= i_rd_data;
            if (!is_mem || acc_misalign) begin
              // Trapped accesses retire immediately without touching the bus.
              o_wb_valid <= 1'b1;
              misalign_q <= is_mem;
              o_rd_wen   <= i_rd_wen & ~is_mem;
              o_rd_addr  <= i_rd_addr;
              o_rd_data  <= i_rd_data;
            end else begin
              o_dmem_valid <= 1'b1;
              state_q      <= StReq;
            end
          end
        end
        StReq: begin
          if (i_dmem_ready) begin
            o_dmem_valid <= 1'b0;
            if (is_load_q) begin
              state_q <= StResp;
            end else begin
              state_q    <= StIdle;
              o_wb_valid <= 1'b1;
              o_rd_wen   <= 1'b0;
              o_rd_addr  <= rd_addr_q;
              o_rd_data  <= o_fwd_rd_data;
            end
          end
        end
        StResp: begin
          if (i_dmem_rvalid) begin
            state_q    <= StIdle;
            o_wb_valid <= 1'b1;
            o_rd_wen   <= rd_wen_q;
            o_rd_addr  <= rd_addr_q;
            o_rd_data  <= load_data;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store stage of the rv64 pipeline, directly downstream of the execute unit. Registers the execute results (acting as the EX/LS pipeline register), performs byte/half/word/double loads and stores over a 64-bit data-memory handshake bus, and delivers write-back results. It stalls upstream while a memory access is outstanding and provides the EX/LS forwarding value.

## Interface
Parameters:
- ADDR_W, 32, data address width
- DATA_W, 64, data width; fixed at 64

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  EX presents an instruction this cycle
- i_rd_wen / i_rd_addr / i_rd_data  in  1/5/64  EX write-back control, destination and ALU result
- i_mem_addr  in  32  effective address (ALU add result)
- i_mem_wdata  in  64  forwarded rs2 store data
- i_ls_info  in  11  one-hot: [10]lb [9]lh [8]lw [7]ld [6]lbu [5]lhu [4]lwu [3]sb [2]sh [1]sw [0]sd
- i_mem_read / i_mem_write  in  1/1  load / store qualifier
- o_stall  out  1  upstream must hold; i_valid is ignored while high
- o_fwd_rd_data  out  64  registered ALU result of the instruction held in this stage
- o_dmem_valid  out  1  request valid
- i_dmem_ready  in  1  request accepted
- o_dmem_addr  out  32  8-byte-aligned address
- o_dmem_wen  out  1  1 = store
- o_dmem_wdata / o_dmem_wmask  out  64/8  lane-replicated data, byte enables
- i_dmem_rvalid / i_dmem_rdata  in  1/64  load response
- o_wb_valid  out  1  one-cycle pulse: result for WB
- o_rd_wen / o_rd_addr / o_rd_data  out  1/5/64  write-back
- o_misalign  out  1  misaligned-access pulse (see Configuration)

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE, i_valid, not a memory op: latch; next cycle o_wb_valid=1 with latched rd fields.
- IDLE, i_valid with i_mem_read or i_mem_write: latch all inputs, go to REQ. If both are set, read wins.
- REQ: o_dmem_valid=1 with stable addr/wen/wdata/wmask until i_dmem_ready.
  - Store handshake: go to IDLE, pulse o_wb_valid, o_rd_wen=0.
  - Load handshake: go to RESP.
- RESP: wait for i_dmem_rvalid, then go to IDLE and pulse o_wb_valid with the extracted load data and o_rd_wen=latched i_rd_wen.
- i_dmem_rvalid is ignored outside RESP.
- o_stall = (state != IDLE).
- Address: o_dmem_addr = {addr[31:3], 3'b000}; off = addr[2:0].
- Load extract: take rdata >> (off*8). lb/lh/lw sign-extend from bit 7/15/31. lbu/lhu/lwu zero-extend. ld takes all 64 bits.
- Store data:
  - sb: {8{wdata[7:0]}}, mask 8'h01<<off
  - sh: {4{wdata[15:0]}}, mask 8'h03<<off
  - sw: {2{wdata[31:0]}}, mask 8'h0F<<off
  - sd: wdata, mask 8'hFF
- o_fwd_rd_data always shows the latched i_rd_data.

## Timing
- Reset values: state=IDLE. All outputs are 0, including o_dmem_*, o_wb_valid, o_rd_*, o_misalign and o_fwd_rd_data.
- Non-memory instruction accepted at cycle N: o_wb_valid at N+1.
- Memory instruction accepted at N:
  - o_dmem_valid and o_stall rise at N+1.
  - Store with ready at N+1: o_wb_valid at N+2.
  - Load with ready at N+1 and rvalid at N+2: o_wb_valid at N+3. Each extra cycle of ready or rvalid latency adds 1.
- o_wb_valid is registered and lasts exactly one cycle.
- o_rd_* hold their value until the next o_wb_valid.
- Back-to-back: a new i_valid is accepted in the cycle o_stall is low. A memory op therefore accepts its successor in the cycle its result is written back.
- Reset mid-access: immediate return to IDLE and o_dmem_valid drops. A stale rvalid arriving after reset is ignored.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - A misaligned access (lh/lhu/sh with off[0]!=0; lw/lwu/sw with off[1:0]!=0; ld/sd with off!=0) issues no bus request.
  - The FSM stays in IDLE and next cycle pulses o_wb_valid with o_misalign=1 and o_rd_wen=0.
- Undefined: o_misalign is tied 0. off is truncated to the natural alignment of the access size, and the access proceeds normally.

## Structure
- The ls_info bit indices, FSM state encodings and size masks go in defines.v as shared constants; the decoder uses the same ls_info indices.
- One combinational sub-module, lsu_align: load extract/extend and store replicate/mask generation.
- The FSM and pipeline registers live in lsu.

## Test plan
- ALU passthrough: i_valid, rd_addr=5, rd_data=0x1234, mem ops off -> o_wb_valid at N+1 with o_rd_data=0x1234, o_rd_wen=1, no o_dmem_valid.
- lb: addr=0x80000003, rdata=0x00000000_80FF0000, ready and rvalid immediate -> o_dmem_addr=0x80000000, o_rd_data=0xFFFFFFFF_FFFFFF80 at N+3; lbu gives 0x80.
- sh: addr=0x80000006, wdata=0xABCD -> wdata=0xABCDABCD_ABCDABCD, wmask=8'hC0, wen=1; o_wb_valid with rd_wen=0.
- Backpressure: ready held low 4 cycles, then rvalid 3 cycles later -> request fields stable, o_stall high throughout, i_valid pulses during stall are ignored.
- Reset asserted in RESP, then rvalid arrives -> all outputs 0, no o_wb_valid.
- With LSU_MISALIGN_CHECK_EN, lw at addr 0x80000002 -> no o_dmem_valid, o_misalign=1 and o_wb_valid=1 at N+1.
